// File: rtl/alu_seq_pkg.sv
// Shared op-code constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_DRTAC = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_AND   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
    localparam logic [OP_W-1:0] OP_COM   = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd8;
    localparam logic [OP_W-1:0] OP_INC   = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Codes above MUL are reserved: accepted but leave result/flags untouched.
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op > OP_MUL;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] dr;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, ac, dr,
        input  result, carry, zero, busy, done
    );

    modport slave (
        input  start, op, ac, dr,
        output result, carry, zero, busy, done
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, LSB first.
module alu_seq_mul #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned CNT_W = $clog2(WIDTH),
    localparam int unsigned PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [PW-1:0]    prod_o
);

    logic [WIDTH-1:0] mcand_q;
    logic [PW-1:0]    prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   step_sum_d;

    // Upper half accumulates the multiplicand; low half holds the unconsumed multiplier bits.
    assign step_sum_d = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            mcand_q <= a_i;
            prod_q  <= {WIDTH'(0), b_i};
            cnt_q   <= CNT_W'(WIDTH - 1);
        end else if (step_i) begin
            prod_q <= {step_sum_d, prod_q[WIDTH-1:1]};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete on the accepting edge, MUL runs WIDTH+1 cycles.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned WW    = WIDTH + 1;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] alu_res_d;
    logic             alu_carry_d;
    logic             alu_wr_d;
    logic [WW-1:0]    wide_sum_d;

    logic             mul_load_c;
    logic             mul_step_c;
    logic [CNT_W-1:0] mul_cnt;
    logic [PW-1:0]    mul_prod;

    // Single-cycle datapath straight off the request inputs; MUL and reserved codes do not write.
    always_comb begin
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_wr_d    = 1'b1;
        wide_sum_d  = '0;
        case (bus.op)
            OP_ADD: begin
                wide_sum_d  = {1'b0, bus.ac} + {1'b0, bus.dr};
                alu_res_d   = wide_sum_d[WIDTH-1:0];
                alu_carry_d = wide_sum_d[WIDTH];
            end
            OP_DRTAC: alu_res_d = bus.dr;
            OP_SUB: begin
                alu_res_d   = bus.ac - bus.dr;
                alu_carry_d = (bus.ac >= bus.dr);
            end
            OP_OR:  alu_res_d = bus.ac | bus.dr;
            OP_AND: alu_res_d = bus.ac & bus.dr;
            OP_XOR: alu_res_d = bus.ac ^ bus.dr;
            OP_COM: alu_res_d = ~bus.ac;
            OP_SHL: begin
                alu_res_d   = {bus.ac[WIDTH-2:0], 1'b0};
                alu_carry_d = bus.ac[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_d   = {1'b0, bus.ac[WIDTH-1:1]};
                alu_carry_d = bus.ac[0];
            end
            OP_INC: begin
                wide_sum_d  = {1'b0, bus.ac} + WW'(1);
                alu_res_d   = wide_sum_d[WIDTH-1:0];
                alu_carry_d = wide_sum_d[WIDTH];
            end
            default: alu_wr_d = 1'b0;
        endcase
    end

    assign mul_load_c = (state_q == ST_IDLE) && bus.start && (bus.op == OP_MUL);
    assign mul_step_c = (state_q == ST_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load_i (mul_load_c),
        .step_i (mul_step_c),
        .a_i    (bus.ac),
        .b_i    (bus.dr),
        .cnt_o  (mul_cnt),
        .prod_o (mul_prod)
    );

    // Control FSM with registered result, flags, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            if (alu_wr_d && !is_reserved(bus.op)) begin
                                result_q <= alu_res_d;
                                carry_q  <= alu_carry_d;
                                zero_q   <= (alu_res_d == '0);
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == '0) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    result_q <= mul_prod[WIDTH-1:0];
                    carry_q  <= |mul_prod[PW-1:WIDTH];
                    zero_q   <= (mul_prod[WIDTH-1:0] == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected responses, a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        string      name;
        logic [W-1:0] res;
        logic       c;
        logic       z;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, 32'(bus.result), 32'(mon_e.res));
                check({mon_e.name, "_carry"},  32'(bus.carry),  32'(mon_e.c));
                check({mon_e.name, "_zero"},   32'(bus.zero),   32'(mon_e.z));
                check({mon_e.name, "_cycle"},  32'(cyc),        32'(mon_e.cyc));
                check({mon_e.name, "_busy0"},  32'(bus.busy),   32'd0);
            end
        end
    end

    // Called at posedge+1; returns in the cycle done is expected high. d = edges from accept to done.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                         input logic ez, input int d, input bit poke);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.ac    = a;
        bus.dr    = b;
        e.name = name;
        e.res  = er;
        e.c    = ec;
        e.z    = ez;
        e.cyc  = cyc + 1 + d;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ac    = ~a;
        bus.dr    = ~b;
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            check({name, "_busy"}, 32'(bus.busy), 32'd1);
            bus.start = poke && (i == 4);
            if (poke && i == 4) begin
                bus.op = OP_ADD;
                bus.ac = 16'h0001;
                bus.dr = 16'h0001;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.ac    = '0;
        bus.dr    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_carry",  32'(bus.carry),  32'd0);
        check("rst_zero",   32'(bus.zero),   32'd1);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        @(posedge clk); #1;

        issue("add_wrap", OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        issue("sub_neg",  OP_SUB,   16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
        issue("shl",      OP_SHL,   16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, 0, 1'b0);
        issue("shr",      OP_SHR,   16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0, 0, 1'b0);
        issue("com",      OP_COM,   16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 0, 1'b0);
        issue("or",       OP_OR,    16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 0, 1'b0);
        issue("and",      OP_AND,   16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 0, 1'b0);
        issue("xor",      OP_XOR,   16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1'b0, 0, 1'b0);
        issue("sub_eq",   OP_SUB,   16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        issue("inc",      OP_INC,   16'h0041, 16'h0000, 16'h0042, 1'b0, 1'b0, 0, 1'b0);
        issue("mul_a",    OP_MUL,   16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, W + 1, 1'b1);
        issue("mul_ovf",  OP_MUL,   16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b1, W + 1, 1'b0);
        issue("mul_b",    OP_MUL,   16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, W + 1, 1'b0);
        issue("drtac",    OP_DRTAC, 16'h5555, 16'h1234, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
        issue("rsvd13",   4'd13,    16'hAAAA, 16'h5555, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
        issue("inc_wrap", OP_INC,   16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        issue("drtac2",   OP_DRTAC, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 0, 1'b0);

        // Abort a multiply with reset partway through; no done may follow.
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.ac    = 16'h0101;
        bus.dr    = 16'h0303;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_done",   32'(bus.done),   32'd0);
        check("abort_result", 32'(bus.result), 32'h0);
        check("abort_carry",  32'(bus.carry),  32'd0);
        check("abort_zero",   32'(bus.zero),   32'd1);
        repeat (W + 4) @(posedge clk);
        #1;
        issue("add_after", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
